// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader
// Collects a serial stream of unsigned elements into operand matrices A then B
// (row-major, 2*N*N elements per frame) and presents them as flat buses for
// the 4x4 parallel matrix multiplier. Frames whose last-element marker does
// not line up with the element count are flagged and discarded.
//
// Optional feature macro: MATLOAD_DBUF_EN
//   undefined : one register set, which is filled and then held for the consumer.
//   defined   : separate assembly and output registers, so the next frame can be
//               collected while the current one waits for mat_ready_i.
module matrix_stream_loader #(
    parameter int ELEM_W = 3,
    parameter int N      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ELEM_W-1:0]     in_data_i,
    input  logic                  in_last_i,
    output logic                  mat_valid_o,
    input  logic                  mat_ready_i,
    output logic [N*N*ELEM_W-1:0] a_flat_o,
    output logic [N*N*ELEM_W-1:0] b_flat_o,
    output logic                  frame_err_o
);
    localparam int FRAME = 2 * N * N;
    localparam int MAT_W = N * N * ELEM_W;
    localparam int CNT_W = $clog2(FRAME);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

    // S_LOAD  : collecting elements.
    // S_DRAIN : dropping the tail of a frame that overran its length.
    // S_HOLD  : no room for more elements. Single buffer: the output frame is
    //           being presented. Double buffer: the output is presented and
    //           the assembly register also holds a complete frame.
    typedef enum logic [1:0] {S_LOAD, S_HOLD, S_DRAIN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_err_q, frame_err_d;
    logic [2*MAT_W-1:0] asm_q, asm_d;   // A in the low half, B in the high half
    logic               accept;
    logic               at_end;
    logic               store;

    assign in_ready_o = (state_q != S_HOLD);
    assign accept     = in_valid_i & in_ready_o;
    assign at_end     = (cnt_q == CNT_LAST);
    // An element is kept only when its marker agrees with its position; a
    // marker mismatch aborts the frame, so that element is never written.
    assign store      = (state_q == S_LOAD) && accept && (at_end == in_last_i);

`ifdef MATLOAD_DBUF_EN
    logic [2*MAT_W-1:0] out_q, out_d;
    logic               out_vld_q, out_vld_d;
    logic               out_free;

    // Output register can take a frame now: empty, or being handed off this cycle.
    assign out_free = !out_vld_q || mat_ready_i;
`endif

    // Next-state: element counting, framing checks and hand-off sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (!at_end) begin
                        if (in_last_i) begin
                            frame_err_d = 1'b1;     // early last: restart the frame
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (in_last_i) begin
                        cnt_d = '0;
`ifdef MATLOAD_DBUF_EN
                        if (!out_free) state_d = S_HOLD;
`else
                        state_d = S_HOLD;
`endif
                    end else begin
                        frame_err_d = 1'b1;         // missing last: skip to the marker
                        state_d     = S_DRAIN;
                    end
                end
            end
            S_HOLD: begin
                if (mat_ready_i) state_d = S_LOAD;
            end
            S_DRAIN: begin
                if (accept && in_last_i) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Write the incoming element into its row-major slot of the assembly frame.
    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < FRAME; k++) begin
            if (store && (cnt_q == CNT_W'(k))) asm_d[k*ELEM_W +: ELEM_W] = in_data_i;
        end
    end

    // Control and assembly registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            asm_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            asm_q       <= asm_d;
        end
    end

`ifdef MATLOAD_DBUF_EN
    // Output register: released on hand-off, reloaded from a finished frame
    // (the one completing this cycle, or the one parked in the assembly register).
    always_comb begin
        out_d     = out_q;
        out_vld_d = out_vld_q;
        if (out_vld_q && mat_ready_i) out_vld_d = 1'b0;
        if (store && at_end && out_free) begin
            out_d     = asm_d;
            out_vld_d = 1'b1;
        end else if ((state_q == S_HOLD) && mat_ready_i) begin
            out_d     = asm_q;
            out_vld_d = 1'b1;
        end
    end

    // Output register state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign mat_valid_o = out_vld_q;
    assign a_flat_o    = out_q[MAT_W-1:0];
    assign b_flat_o    = out_q[2*MAT_W-1:MAT_W];
`else
    assign mat_valid_o = (state_q == S_HOLD);
    assign a_flat_o    = asm_q[MAT_W-1:0];
    assign b_flat_o    = asm_q[2*MAT_W-1:MAT_W];
`endif

    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader. A transaction-level model
// (queue of collected elements, presented/parked frame vectors) predicts
// outputs; each scenario task checks the DUT against it or against constants.
module tb_matrix_stream_loader;
    localparam int ELEM_W = 3;
    localparam int N      = 4;
    localparam int NN     = N * N;
    localparam int FRAME  = 2 * NN;
    localparam int MW     = NN * ELEM_W;
    localparam int FW     = 2 * MW;
`ifdef MATLOAD_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              mat_ready = 1'b0;
    logic [ELEM_W-1:0] in_data = '0;
    logic              in_ready, mat_valid, frame_err;
    logic [MW-1:0]     a_flat, b_flat;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int          m_elems[$];
    bit          m_drain, m_hold, m_asm_full, m_err, m_acc;
    logic [FW-1:0] m_out, m_asm;
    int          m_nout = 0;

    always #5 clk = ~clk;

    matrix_stream_loader #(.ELEM_W(ELEM_W), .N(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .mat_valid_o (mat_valid),
        .mat_ready_i (mat_ready),
        .a_flat_o    (a_flat),
        .b_flat_o    (b_flat),
        .frame_err_o (frame_err)
    );

    function automatic bit m_rdy();
        return DBUF ? !m_asm_full : !m_hold;
    endfunction

    task automatic model_reset();
        m_elems.delete();
        m_drain = 0; m_hold = 0; m_asm_full = 0; m_err = 0; m_acc = 0;
        m_out = '0; m_asm = '0;
    endtask

    // Advance one clock, updating the model from the inputs applied this cycle.
    task automatic step();
        bit            acc, hs, newf;
        logic [FW-1:0] f;
        f    = '0;
        newf = 0;
        acc  = in_valid && m_rdy();
        hs   = m_hold && mat_ready;
        m_err = 0;
        if (acc) begin
            if (m_drain) begin
                if (in_last) m_drain = 0;
            end else if (m_elems.size() < FRAME - 1) begin
                if (in_last) begin m_err = 1; m_elems.delete(); end
                else m_elems.push_back(int'(in_data));
            end else begin
                if (in_last) begin
                    m_elems.push_back(int'(in_data));
                    for (int k = 0; k < FRAME; k++) f[k*ELEM_W +: ELEM_W] = ELEM_W'(m_elems[k]);
                    newf = 1;
                end else begin
                    m_err = 1; m_drain = 1;
                end
                m_elems.delete();
            end
        end
        if (hs) begin
            m_nout++;
            if (m_asm_full) begin m_out = m_asm; m_asm_full = 0; end
            else m_hold = 0;
        end
        if (newf) begin
            if (!m_hold) begin m_out = f; m_hold = 1; end
            else begin m_asm = f; m_asm_full = 1; end
        end
        m_acc = acc;
        @(posedge clk); #1;
    endtask

    // Drive one element and wait (bounded) until the model accepts it.
    task automatic send_elem(input logic [ELEM_W-1:0] d, input bit last);
        int w = 0;
        in_valid = 1; in_data = d; in_last = last;
        do begin step(); w++; end while (!m_acc && w < 64);
        if (!m_acc) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready=%b, no accept within 64 cycles", in_ready);
        end
    endtask

    task automatic send_rand_frame();
        for (int k = 0; k < FRAME; k++) send_elem(ELEM_W'($urandom), k == FRAME - 1);
        in_valid = 0; in_last = 0;
    endtask

    task automatic idle_consume();
        in_valid = 0; in_last = 0; mat_ready = 1;
        step(); step();
        mat_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; mat_ready = 0;
        model_reset();
        @(posedge clk); #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        n_chk++; if (mat_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mat_valid: got %b exp 0", mat_valid); end
        n_chk++; if (a_flat !== '0) begin n_fail++; $display("FAIL reset_a_flat: got %h exp 0", a_flat); end
        n_chk++; if (b_flat !== '0) begin n_fail++; $display("FAIL reset_b_flat: got %h exp 0", b_flat); end
        n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b exp 0", frame_err); end
        rst = 0;
        step();
    endtask

    task automatic test_clean_frame();
        logic [MW-1:0] ones = 48'o1111111111111111;
        mat_ready = 1;
        for (int k = 0; k < FRAME; k++) send_elem(3'd1, k == FRAME - 1);
        in_valid = 0; in_last = 0;
        n_chk++; if (mat_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid: got %b exp 1", mat_valid); end
        n_chk++; if (a_flat !== ones) begin n_fail++; $display("FAIL clean_a: got %o exp %o", a_flat, ones); end
        n_chk++; if (b_flat !== ones) begin n_fail++; $display("FAIL clean_b: got %o exp %o", b_flat, ones); end
        step();
        n_chk++; if (mat_valid !== 1'b0) begin n_fail++; $display("FAIL clean_valid_drop: got %b exp 0", mat_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clean_ready_back: got %b exp 1", in_ready); end
        mat_ready = 0;
    endtask

    task automatic test_packing();
        int av[NN] = '{5,0,2,0, 1,4,5,1, 1,0,6,3, 5,5,3,7};
        int bv[NN] = '{1,5,6,6, 7,6,6,4, 4,4,0,2, 4,6,3,1};
        int res = 0;
        mat_ready = 0;
        for (int k = 0; k < NN; k++) send_elem(ELEM_W'(av[k]), 1'b0);
        for (int k = 0; k < NN; k++) send_elem(ELEM_W'(bv[k]), k == NN - 1);
        in_valid = 0; in_last = 0;
        for (int k = 0; k < N; k++)
            res += int'(a_flat[ELEM_W*k +: ELEM_W]) * int'(b_flat[ELEM_W*N*k +: ELEM_W]);
        n_chk++; if (a_flat[2:0] !== 3'd5) begin n_fail++; $display("FAIL pack_a00: got %0d exp 5", a_flat[2:0]); end
        n_chk++; if (a_flat[47:45] !== 3'd7) begin n_fail++; $display("FAIL pack_a33: got %0d exp 7", a_flat[47:45]); end
        n_chk++; if (b_flat[5:3] !== 3'd5) begin n_fail++; $display("FAIL pack_b01: got %0d exp 5", b_flat[5:3]); end
        n_chk++; if (res != 13) begin n_fail++; $display("FAIL pack_res00: got %0d exp 13", res); end
        n_chk++; if ({b_flat, a_flat} !== m_out) begin n_fail++; $display("FAIL pack_flats: got %h exp %h", {b_flat, a_flat}, m_out); end
        idle_consume();
    endtask

    task automatic test_backpressure();
        mat_ready = 0;
        send_rand_frame();
        // keep offering an element while held; it must be ignored without a double buffer
        in_valid = !DBUF; in_data = 3'd7; in_last = 1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_chk++; if (in_ready !== m_rdy()) begin n_fail++; $display("FAIL bp_ready c%0d: got %b exp %b", c, in_ready, m_rdy()); end
            n_chk++; if (mat_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d: got %b exp 1", c, mat_valid); end
            n_chk++; if ({b_flat, a_flat} !== m_out) begin n_fail++; $display("FAIL bp_stable c%0d: got %h exp %h", c, {b_flat, a_flat}, m_out); end
        end
        in_valid = 0; in_last = 0; mat_ready = 1;
        step();
        mat_ready = 0;
        n_chk++; if (mat_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b exp 0", mat_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_early_last();
        mat_ready = 1;
        for (int k = 0; k < 10; k++) send_elem(ELEM_W'($urandom), k == 9);
        in_valid = 0; in_last = 0;
        n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL early_err: got %b exp 1", frame_err); end
        n_chk++; if (mat_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %b exp 0", mat_valid); end
        step();
        n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL early_err_pulse: got %b exp 0", frame_err); end
        send_rand_frame();
        n_chk++; if (mat_valid !== 1'b1) begin n_fail++; $display("FAIL early_next_valid: got %b exp 1", mat_valid); end
        n_chk++; if ({b_flat, a_flat} !== m_out) begin n_fail++; $display("FAIL early_next_data: got %h exp %h", {b_flat, a_flat}, m_out); end
        idle_consume();
    endtask

    task automatic test_missing_last();
        mat_ready = 1;
        for (int k = 0; k < FRAME; k++) send_elem(ELEM_W'($urandom), 1'b0);
        n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL miss_err: got %b exp 1", frame_err); end
        n_chk++; if (mat_valid !== 1'b0) begin n_fail++; $display("FAIL miss_valid: got %b exp 0", mat_valid); end
        for (int k = 0; k < 5; k++) begin
            send_elem(ELEM_W'($urandom), k == 4);
            n_chk++; if (frame_err !== 1'b0 || mat_valid !== 1'b0) begin
                n_fail++; $display("FAIL miss_drain e%0d: err=%b valid=%b exp 0 0", k, frame_err, mat_valid);
            end
        end
        in_valid = 0; in_last = 0;
        send_rand_frame();
        n_chk++; if (mat_valid !== 1'b1) begin n_fail++; $display("FAIL miss_next_valid: got %b exp 1", mat_valid); end
        n_chk++; if ({b_flat, a_flat} !== m_out) begin n_fail++; $display("FAIL miss_next_data: got %h exp %h", {b_flat, a_flat}, m_out); end
        idle_consume();
    endtask

    task automatic test_reset_mid();
        mat_ready = 1;
        for (int k = 0; k < 20; k++) send_elem(ELEM_W'($urandom_range(7, 1)), 1'b0);
        in_valid = 0;
        #2 rst = 1;
        #1;
        model_reset();
        n_chk++; if (in_ready !== 1'b1 || mat_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ctrl: ready=%b valid=%b err=%b exp 1 0 0", in_ready, mat_valid, frame_err);
        end
        n_chk++; if (a_flat !== '0 || b_flat !== '0) begin
            n_fail++; $display("FAIL rstmid_flats: a=%h b=%h exp 0 0", a_flat, b_flat);
        end
        @(posedge clk); #1;
        rst = 0;
        send_rand_frame();
        n_chk++; if (mat_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_valid: got %b exp 1", mat_valid); end
        n_chk++; if ({b_flat, a_flat} !== m_out) begin n_fail++; $display("FAIL rstmid_next_data: got %h exp %h", {b_flat, a_flat}, m_out); end
        idle_consume();
    endtask

    task automatic test_back_to_back();
        int start = m_nout;
        int cyc   = 0;
        while ((m_nout - start) < 6 && cyc < 4000) begin
            in_valid = ($urandom_range(3) != 0);
            in_data  = ELEM_W'($urandom);
            if (m_drain)                          in_last = ($urandom_range(3) == 0);
            else if (m_elems.size() == FRAME - 1) in_last = ($urandom_range(7) != 0);
            else                                  in_last = ($urandom_range(63) == 0);
            mat_ready = 1'($urandom_range(1));
            step(); cyc++;
            n_chk++; if (mat_valid !== m_hold) begin n_fail++; $display("FAIL b2b_valid cyc%0d: got %b exp %b", cyc, mat_valid, m_hold); end
            n_chk++; if (in_ready !== m_rdy()) begin n_fail++; $display("FAIL b2b_ready cyc%0d: got %b exp %b", cyc, in_ready, m_rdy()); end
            n_chk++; if (frame_err !== m_err) begin n_fail++; $display("FAIL b2b_err cyc%0d: got %b exp %b", cyc, frame_err, m_err); end
            if (m_hold) begin
                n_chk++; if ({b_flat, a_flat} !== m_out) begin n_fail++; $display("FAIL b2b_data cyc%0d: got %h exp %h", cyc, {b_flat, a_flat}, m_out); end
            end
        end
        n_chk++; if ((m_nout - start) < 6) begin n_fail++; $display("FAIL b2b_timeout: %0d frames delivered, exp 6", m_nout - start); end
        in_valid = 0; in_last = 0;
        idle_consume();
    endtask

`ifdef MATLOAD_DBUF_EN
    task automatic test_dbuf();
        logic [FW-1:0] f1, f2;
        mat_ready = 0;
        send_rand_frame();
        f1 = m_out;
        n_chk++; if (mat_valid !== 1'b1) begin n_fail++; $display("FAIL dbuf_f1_valid: got %b exp 1", mat_valid); end
        for (int k = 0; k < FRAME; k++) begin
            send_elem(ELEM_W'($urandom), k == FRAME - 1);
            if (k < FRAME - 1) begin
                n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dbuf_fill_ready e%0d: got %b exp 1", k, in_ready); end
            end
        end
        in_valid = 0; in_last = 0;
        f2 = m_asm;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL dbuf_full_ready: got %b exp 0", in_ready); end
        n_chk++; if ({b_flat, a_flat} !== f1) begin n_fail++; $display("FAIL dbuf_f1_hold: got %h exp %h", {b_flat, a_flat}, f1); end
        mat_ready = 1;
        step();
        mat_ready = 0;
        n_chk++; if (mat_valid !== 1'b1) begin n_fail++; $display("FAIL dbuf_f2_valid: got %b exp 1", mat_valid); end
        n_chk++; if ({b_flat, a_flat} !== f2) begin n_fail++; $display("FAIL dbuf_f2_data: got %h exp %h", {b_flat, a_flat}, f2); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dbuf_f2_ready: got %b exp 1", in_ready); end
        step();
        n_chk++; if (mat_valid !== 1'b1) begin n_fail++; $display("FAIL dbuf_f2_hold: got %b exp 1", mat_valid); end
        idle_consume();
    endtask
`endif

    initial begin
        test_reset();
        test_clean_frame();
        test_packing();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        test_back_to_back();
`ifdef MATLOAD_DBUF_EN
        test_dbuf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
